// File: rtl/serial_word_adder.sv
// -----------------------------------------------------------------------------
// serial_word_adder
//
// Purpose:
//   Word-level wrapper around a one-bit full adder. Two W-bit operands are
//   accepted on a valid/ready handshake, shifted LSB-first through the
//   single-bit adder one bit per clock, and the serial sum is reassembled
//   into a parallel word. The result and the carry-out of bit W-1 are
//   offered on a second valid/ready handshake.
//
// Handshakes:
//   A transfer happens on a rising clock edge where both valid and ready are
//   high. The producer holds valid and the payload steady until that edge.
//   in_ready is high only in IDLE outside reset. out_valid is high only in
//   DONE. out_sum and out_carry do not change while out_valid is high.
//
// Parameters:
//   W          operand/result width in bits (W >= 1)
//
// Ports:
//   clk        clock, rising edge
//   rst        synchronous active-high reset
//   in_valid   operands on in_a/in_b are valid
//   in_ready   block can accept operands (IDLE and not in reset)
//   in_a       operand A
//   in_b       operand B
//   in_sub     (SERIAL_WORD_ADDER_SUB_EN only) 1 selects A - B
//   out_valid  result is valid (DONE)
//   out_ready  consumer accepts the result
//   out_sum    result word
//   out_carry  carry-out of bit W-1 (for subtraction: 1 means no borrow)
//
// Optional feature:
//   Define SERIAL_WORD_ADDER_SUB_EN to add the in_sub port. Subtraction is
//   done as A + ~B + 1: B is inverted at load and the carry starts at 1.
//
// Timing:
//   Operands accepted at edge k leave out_valid high after edge k+W. One
//   operation takes at least W+2 cycles: IDLE, W x BUSY, DONE.
// -----------------------------------------------------------------------------
module serial_word_adder #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
`ifdef SERIAL_WORD_ADDER_SUB_EN
    input  logic         in_sub,
`endif
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_sum,
    output logic         out_carry
);

    // The counter only has to reach W-1, so W=1 still needs one bit.
    localparam int CW = (W > 1) ? $clog2(W) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [W-1:0]  sa_q, sa_d;
    logic [W-1:0]  sb_q, sb_d;
    logic [W-1:0]  sum_q, sum_d;
    logic          c_q, c_d;
    logic          carry_q, carry_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Single-bit datapath and counter helpers.
    logic          s_bit;
    logic          c_next;
    logic          last_bit;
    logic [CW-1:0] cnt_inc;
    logic          inc_c;

    always_comb begin
        // Full adder on the current LSBs.
        s_bit  = sa_q[0] ^ sb_q[0] ^ c_q;
        c_next = (sa_q[0] & sb_q[0]) | (c_q & (sa_q[0] | sb_q[0]));

        // Ripple incrementer built from XOR/AND so the block needs no adder.
        inc_c   = 1'b1;
        cnt_inc = '0;
        for (int i = 0; i < CW; i++) begin
            cnt_inc[i] = cnt_q[i] ^ inc_c;
            inc_c      = inc_c & cnt_q[i];
        end

        // The counter holds the index of the bit being processed this cycle.
        last_bit = (cnt_q == CW'(W - 1));
    end

    always_comb begin
        state_d = state_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        sum_d   = sum_q;
        c_d     = c_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;

        case (state_q)
            ST_IDLE: begin
                // in_ready is high whenever IDLE is reached outside reset,
                // and reset overrides every register below, so in_valid
                // alone qualifies the accept here.
                if (in_valid) begin
                    sa_d  = in_a;
                    sb_d  = in_b;
                    c_d   = 1'b0;
`ifdef SERIAL_WORD_ADDER_SUB_EN
                    if (in_sub) begin
                        sb_d = ~in_b;
                        c_d  = 1'b1;
                    end
`endif
                    cnt_d   = '0;
                    state_d = ST_BUSY;
                end
            end

            ST_BUSY: begin
                c_d   = c_next;
                sa_d  = sa_q >> 1;
                sb_d  = sb_q >> 1;
                // New sum bits enter at the top, so after W shifts the first
                // (LSB) bit has arrived at bit 0.
                sum_d        = sum_q >> 1;
                sum_d[W-1]   = s_bit;
                cnt_d        = cnt_inc;
                if (last_bit) begin
                    carry_d = c_next;
                    state_d = ST_DONE;
                end
            end

            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            sa_q    <= '0;
            sb_q    <= '0;
            sum_q   <= '0;
            c_q     <= 1'b0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            sum_q   <= sum_d;
            c_q     <= c_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
        end
    end

    // Outputs are forced low while rst is high, even in the cycle before the
    // reset edge has cleared the registers.
    assign in_ready  = (state_q == ST_IDLE) & ~rst;
    assign out_valid = (state_q == ST_DONE) & ~rst;
    assign out_sum   = rst ? '0 : sum_q;
    assign out_carry = carry_q & ~rst;

endmodule

// File: tb/tb_serial_word_adder.sv
// -----------------------------------------------------------------------------
// tb_serial_word_adder
//
// Exercises serial_word_adder at W=8 (main instance) and W=1 (second
// instance). A behavioural model predicts each result as plain W+1-bit
// arithmetic and predicts handshake timing from the accept cycle; a compare
// process checks the DUT against it on every falling edge. Directed cases
// pin the model with hand-computed literals.
// -----------------------------------------------------------------------------
module tb_serial_word_adder;

  localparam int W = 8;

  // ---------------------------------------------------------------- clock/reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // main DUT (W=8)
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_sum;
  logic         out_carry;
`ifdef SERIAL_WORD_ADDER_SUB_EN
  logic         in_sub;
  logic         in_sub1;
`endif

  // second DUT (W=1)
  logic       in_valid1;
  logic       in_ready1;
  logic [0:0] in_a1;
  logic [0:0] in_b1;
  logic       out_valid1;
  logic       out_ready1;
  logic [0:0] out_sum1;
  logic       out_carry1;

  serial_word_adder #(.W(W)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
`ifdef SERIAL_WORD_ADDER_SUB_EN
    .in_sub    (in_sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_carry (out_carry)
  );

  serial_word_adder #(.W(1)) u_dut_w1 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid1),
    .in_ready  (in_ready1),
    .in_a      (in_a1),
    .in_b      (in_b1),
`ifdef SERIAL_WORD_ADDER_SUB_EN
    .in_sub    (in_sub1),
`endif
    .out_valid (out_valid1),
    .out_ready (out_ready1),
    .out_sum   (out_sum1),
    .out_carry (out_carry1)
  );

  // ---------------------------------------------------------------- bookkeeping
  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------- model
  // Result = {carry, sum} of the W+1-bit sum; subtraction is A + ~B + 1.
  function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                       input logic sub);
    logic [W-1:0] bb;
    bb = sub ? ~b : b;
    return {1'b0, a} + {1'b0, bb} + (W+1)'(sub);
  endfunction

  // ---------------------------------------------------------------- scoreboard
  logic [W:0] exp_q[$];   // expected {carry, sum} per accepted operation
  int         acc_q[$];   // clock edge at which each operation was accepted

  always @(negedge clk) begin
    logic exp_ov;
    logic sub_now;
    if (rst) begin
      // Reset aborts whatever was in flight.
      exp_q.delete();
      acc_q.delete();
      check("rst_outputs", 32'({in_ready, out_valid, out_carry, out_sum}), 32'd0);
    end else begin
      check("in_ready", 32'(in_ready), 32'(exp_q.size() == 0));
      exp_ov = (exp_q.size() != 0) && ((cyc - acc_q[0]) >= W);
      check("out_valid", 32'(out_valid), 32'(exp_ov));
      if (exp_ov && out_valid) begin
        check("result", 32'({out_carry, out_sum}), 32'(exp_q[0]));
        if (out_ready) begin
          void'(exp_q.pop_front());
          void'(acc_q.pop_front());
        end
      end
      if (in_valid && in_ready) begin
`ifdef SERIAL_WORD_ADDER_SUB_EN
        sub_now = in_sub;
`else
        sub_now = 1'b0;
`endif
        exp_q.push_back(model(in_a, in_b, sub_now));
        acc_q.push_back(cyc + 1);
      end
    end
  end

  // ---------------------------------------------------------------- drivers
  // All driver tasks start and end at posedge + #1.
  task automatic do_accept(input logic [W-1:0] a, input logic [W-1:0] b);
    int n;
    in_a     = a;
    in_b     = b;
    in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      check("accept_timeout", 32'd0, 32'd1);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic op(input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef SERIAL_WORD_ADDER_SUB_EN
    in_sub = 1'b0;
`endif
    do_accept(a, b);
  endtask

`ifdef SERIAL_WORD_ADDER_SUB_EN
  task automatic op_sub(input logic [W-1:0] a, input logic [W-1:0] b);
    in_sub = 1'b1;
    do_accept(a, b);
  endtask
`endif

  // Waits for the output handshake and compares against literal values.
  task automatic expect_result(input string name, input logic [W-1:0] sum,
                               input logic carry);
    int n;
    n = 0;
    @(negedge clk);
    while (!(out_valid && out_ready) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!(out_valid && out_ready)) begin
      check({name, "_timeout"}, 32'd0, 32'd1);
    end else begin
      check(name, 32'({out_carry, out_sum}), 32'({carry, sum}));
    end
    @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------- watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d fails=%0d", tests, fails);
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------- main
  initial begin
    int n;
    logic [W-1:0] ra;
    logic [W-1:0] rb;

    rst        = 1'b1;
    in_valid   = 1'b0;
    in_a       = '0;
    in_b       = '0;
    out_ready  = 1'b1;
    in_valid1  = 1'b0;
    in_a1      = '0;
    in_b1      = '0;
    out_ready1 = 1'b1;
`ifdef SERIAL_WORD_ADDER_SUB_EN
    in_sub     = 1'b0;
    in_sub1    = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_reset", 32'({in_ready, out_valid, out_carry, out_sum}),
          32'({1'b1, 1'b0, 1'b0, 8'h00}));
    @(posedge clk);
    #1;

    // Basic add
    op(8'h5A, 8'h3C);
    expect_result("basic_add", 8'h96, 1'b0);

    // Overflow, then back-to-back operation (carry must not leak)
    op(8'hFF, 8'h01);
    expect_result("overflow", 8'h00, 1'b1);
    op(8'h80, 8'h80);
    expect_result("overflow_b2b", 8'h00, 1'b1);
    op(8'h01, 8'h01);
    expect_result("no_carry_leak", 8'h02, 1'b0);

    // Backpressure: result held in DONE while a new request is ignored
    out_ready = 1'b0;
    op(8'h12, 8'h34);
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("bp_reach_done", 32'(out_valid), 32'd1);
    @(posedge clk);
    #1;
    in_a     = 8'h11;
    in_b     = 8'h22;
    in_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("bp_hold", 32'({in_ready, out_valid, out_carry, out_sum}),
            32'({1'b0, 1'b1, 1'b0, 8'h46}));
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    expect_result("bp_result", 8'h46, 1'b0);
    op(8'h11, 8'h22);
    expect_result("bp_fresh", 8'h33, 1'b0);

    // Reset in the middle of BUSY
    op(8'h55, 8'h55);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_abort", 32'({in_ready, out_valid, out_carry, out_sum}),
          32'({1'b1, 1'b0, 1'b0, 8'h00}));
    @(posedge clk);
    #1;
    op(8'h0F, 8'h01);
    expect_result("after_abort", 8'h10, 1'b0);

`ifdef SERIAL_WORD_ADDER_SUB_EN
    op_sub(8'h10, 8'h01);
    expect_result("sub_no_borrow", 8'h0F, 1'b1);
    op_sub(8'h01, 8'h02);
    expect_result("sub_borrow", 8'hFF, 1'b0);
    op(8'h7F, 8'h01);
    expect_result("add_after_sub", 8'h80, 1'b0);
`endif

    // Randomized operations with random consumer backpressure
    for (int i = 0; i < 40; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
`ifdef SERIAL_WORD_ADDER_SUB_EN
      if ($urandom_range(0, 1) == 1) op_sub(ra, rb);
      else op(ra, rb);
`else
      op(ra, rb);
`endif
      n = 0;
      while (exp_q.size() != 0 && n < 200) begin
        @(posedge clk);
        #1;
        out_ready = 1'($urandom_range(0, 1));
        n++;
      end
      check("rand_drain", 32'(exp_q.size()), 32'd0);
      out_ready = 1'b1;
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
    end

    // W=1 instance: 1+1 -> sum 0, carry 1, valid one cycle after accept
    @(negedge clk);
    check("w1_idle", 32'({in_ready1, out_valid1}), 32'({1'b1, 1'b0}));
    @(posedge clk);
    #1;
    in_a1     = 1'b1;
    in_b1     = 1'b1;
    in_valid1 = 1'b1;
    @(posedge clk);
    #1;
    in_valid1 = 1'b0;
    @(negedge clk);
    check("w1_busy", 32'({in_ready1, out_valid1}), 32'({1'b0, 1'b0}));
    @(negedge clk);
    check("w1_valid", 32'(out_valid1), 32'd1);
    check("w1_result", 32'({out_carry1, out_sum1}), 32'({1'b1, 1'b0}));
    @(negedge clk);
    check("w1_back_idle", 32'({in_ready1, out_valid1}), 32'({1'b1, 1'b0}));

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
